router_fsm: RTL and testbench

//  Write-side sequencer for the 1x3 router. Decodes the header byte's 2-bit destination,

---
 rtl/router_fsm.sv | 242 ++++++++++++++++++++++++
 tb/tb_router_fsm.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/router_fsm.sv
// router_fsm: write-side sequencer for the 1x3 router.
// Decodes the header address and picks the destination FIFO. It drives the
// header/payload/parity load strobes and stalls the source while that FIFO is full.
// Output flops are loaded from the decode of the next state. They therefore
// change on the same clock as the state register, with no added latency.
module router_fsm #(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  pkt_valid,
    input  logic [DATA_WIDTH-1:0] data_in,
    input  logic                  fifo_full_0,
    input  logic                  fifo_full_1,
    input  logic                  fifo_full_2,
    input  logic                  fifo_empty_0,
    input  logic                  fifo_empty_1,
    input  logic                  fifo_empty_2,
    input  logic                  soft_reset_0,
    input  logic                  soft_reset_1,
    input  logic                  soft_reset_2,
    input  logic                  parity_done,
    input  logic                  low_pkt_valid,
    output logic [2:0]            fifo_sel,
    output logic                  write_enb_reg,
    output logic                  detect_add,
    output logic                  lfd_state,
    output logic                  ld_state,
    output logic                  laf_state,
    output logic                  full_state,
    output logic                  rst_int_reg,
    output logic                  busy
);

    typedef enum logic [2:0] {
        DECODE_ADDRESS     = 3'd0,
        WAIT_TILL_EMPTY    = 3'd1,
        LOAD_FIRST_DATA    = 3'd2,
        LOAD_DATA          = 3'd3,
        FIFO_FULL_STATE    = 3'd4,
        LOAD_AFTER_FULL    = 3'd5,
        LOAD_PARITY        = 3'd6,
        CHECK_PARITY_ERROR = 3'd7
    } state_t;

    // Address 3 is not a port. The spare top entry of each status vector is
    // tied low, so indexing with any 2-bit value stays in range.
    function automatic logic [2:0] onehot3(input logic [1:0] a);
        logic [2:0] r;
        case (a)
            2'd0:    r = 3'b001;
            2'd1:    r = 3'b010;
            2'd2:    r = 3'b100;
            default: r = 3'b000;
        endcase
        return r;
    endfunction

    state_t     state_q, state_d;
    logic [1:0] addr_q, addr_d;
    logic [2:0] fifo_sel_q, fifo_sel_d;
    logic       write_enb_q, write_enb_d;
    logic       detect_add_q, detect_add_d;
    logic       lfd_q, lfd_d;
    logic       ld_q, ld_d;
    logic       laf_q, laf_d;
    logic       full_state_q, full_state_d;
    logic       rst_int_q, rst_int_d;
    logic       busy_q, busy_d;

    logic [3:0] full_v_s, empty_v_s, srst_v_s;
    logic [1:0] live_addr_s, look_addr_s;
    logic       live_ok_s, soft_hit_s, cur_full_s, cur_empty_s;
    logic       unused_data_s;

    assign unused_data_s = ^data_in[DATA_WIDTH-1:2];

    // Collect per-FIFO status and select the entry for the current address.
    always_comb begin
        full_v_s    = {1'b0, fifo_full_2, fifo_full_1, fifo_full_0};
        empty_v_s   = {1'b0, fifo_empty_2, fifo_empty_1, fifo_empty_0};
        srst_v_s    = {1'b0, soft_reset_2, soft_reset_1, soft_reset_0};
        live_addr_s = data_in[1:0];
        live_ok_s   = (live_addr_s != 2'b11);
        if (state_q == DECODE_ADDRESS) begin
            look_addr_s = live_addr_s;
        end else begin
            look_addr_s = addr_q;
        end
        soft_hit_s  = srst_v_s[look_addr_s];
        cur_full_s  = full_v_s[look_addr_s];
        cur_empty_s = empty_v_s[look_addr_s];
    end

    // Next-state and address-latch logic; a read-side soft reset overrides all.
    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        fifo_sel_d = fifo_sel_q;
        if ((state_q == DECODE_ADDRESS) && pkt_valid && live_ok_s) begin
            addr_d     = live_addr_s;
            fifo_sel_d = onehot3(live_addr_s);
        end else begin
            addr_d     = addr_q;
            fifo_sel_d = fifo_sel_q;
        end
        if (soft_hit_s) begin
            state_d = DECODE_ADDRESS;
        end else begin
            case (state_q)
                DECODE_ADDRESS: begin
                    if (pkt_valid && live_ok_s && cur_empty_s) begin
                        state_d = LOAD_FIRST_DATA;
                    end else if (pkt_valid && live_ok_s) begin
                        state_d = WAIT_TILL_EMPTY;
                    end else begin
                        state_d = DECODE_ADDRESS;
                    end
                end
                WAIT_TILL_EMPTY: begin
                    if (cur_empty_s) begin
                        state_d = LOAD_FIRST_DATA;
                    end else begin
                        state_d = WAIT_TILL_EMPTY;
                    end
                end
                LOAD_FIRST_DATA: state_d = LOAD_DATA;
                LOAD_DATA: begin
                    // A full FIFO takes priority over end-of-packet; parity follows LAF.
                    if (cur_full_s) begin
                        state_d = FIFO_FULL_STATE;
                    end else if (!pkt_valid) begin
                        state_d = LOAD_PARITY;
                    end else begin
                        state_d = LOAD_DATA;
                    end
                end
                FIFO_FULL_STATE: begin
                    if (!cur_full_s) begin
                        state_d = LOAD_AFTER_FULL;
                    end else begin
                        state_d = FIFO_FULL_STATE;
                    end
                end
                LOAD_AFTER_FULL: begin
                    if (parity_done) begin
                        state_d = DECODE_ADDRESS;
                    end else if (low_pkt_valid) begin
                        state_d = LOAD_PARITY;
                    end else begin
                        state_d = LOAD_DATA;
                    end
                end
                LOAD_PARITY: state_d = CHECK_PARITY_ERROR;
                CHECK_PARITY_ERROR: begin
                    if (cur_full_s) begin
                        state_d = FIFO_FULL_STATE;
                    end else begin
                        state_d = DECODE_ADDRESS;
                    end
                end
                default: state_d = DECODE_ADDRESS;
            endcase
        end
    end

    // Moore decode of the upcoming state into the registered control outputs.
    always_comb begin
        detect_add_d = 1'b0;
        lfd_d        = 1'b0;
        ld_d         = 1'b0;
        laf_d        = 1'b0;
        full_state_d = 1'b0;
        rst_int_d    = 1'b0;
        busy_d       = 1'b1;
        write_enb_d  = 1'b0;
        case (state_d)
            DECODE_ADDRESS: begin
                detect_add_d = 1'b1;
                busy_d       = 1'b0;
            end
            WAIT_TILL_EMPTY: busy_d = 1'b1;
            LOAD_FIRST_DATA: lfd_d = 1'b1;
            LOAD_DATA: begin
                ld_d        = 1'b1;
                busy_d      = 1'b0;
                write_enb_d = 1'b1;
            end
            FIFO_FULL_STATE: full_state_d = 1'b1;
            LOAD_AFTER_FULL: begin
                laf_d       = 1'b1;
                write_enb_d = 1'b1;
            end
            LOAD_PARITY: write_enb_d = 1'b1;
            CHECK_PARITY_ERROR: rst_int_d = 1'b1;
            default: begin
                detect_add_d = 1'b1;
                busy_d       = 1'b0;
            end
        endcase
    end

    // State, latched address and registered outputs; async reset aborts any packet.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q      <= DECODE_ADDRESS;
            addr_q       <= 2'b00;
            fifo_sel_q   <= 3'b000;
            detect_add_q <= 1'b1;
            lfd_q        <= 1'b0;
            ld_q         <= 1'b0;
            laf_q        <= 1'b0;
            full_state_q <= 1'b0;
            rst_int_q    <= 1'b0;
            busy_q       <= 1'b0;
            write_enb_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            addr_q       <= addr_d;
            fifo_sel_q   <= fifo_sel_d;
            detect_add_q <= detect_add_d;
            lfd_q        <= lfd_d;
            ld_q         <= ld_d;
            laf_q        <= laf_d;
            full_state_q <= full_state_d;
            rst_int_q    <= rst_int_d;
            busy_q       <= busy_d;
            write_enb_q  <= write_enb_d;
        end
    end

    assign fifo_sel      = fifo_sel_q;
    assign write_enb_reg = write_enb_q;
    assign detect_add    = detect_add_q;
    assign lfd_state     = lfd_q;
    assign ld_state      = ld_q;
    assign laf_state     = laf_q;
    assign full_state    = full_state_q;
    assign rst_int_reg   = rst_int_q;
    assign busy          = busy_q;

endmodule

// File: tb/tb_router_fsm.sv
// Bench for router_fsm: a table-driven packet, directed corner sequences,
// then randomized traffic checked against a rule-level reference model.
module tb_router_fsm;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       pv = 1'b0;
    logic [7:0] din = 8'h00;
    logic [2:0] full = 3'b000;
    logic [2:0] empty = 3'b111;
    logic [2:0] sr = 3'b000;
    logic       pd = 1'b0;
    logic       lpv = 1'b0;

    logic [2:0] fifo_sel;
    logic       write_enb_reg, detect_add, lfd_state, ld_state, laf_state;
    logic       full_state, rst_int_reg, busy;

    int tests = 0;
    int fails = 0;

    // Reference-model state. The numbering is this bench's own.
    localparam int M_DA = 10, M_WTE = 11, M_LFD = 12, M_LD = 13;
    localparam int M_FFS = 14, M_LAF = 15, M_LP = 16, M_CPE = 17;
    int         ms = M_DA;
    int         maddr = 0;
    logic [2:0] msel = 3'b000;

    router_fsm #(.DATA_WIDTH(8)) dut (
        .clock(clock), .reset(reset), .pkt_valid(pv), .data_in(din),
        .fifo_full_0(full[0]), .fifo_full_1(full[1]), .fifo_full_2(full[2]),
        .fifo_empty_0(empty[0]), .fifo_empty_1(empty[1]), .fifo_empty_2(empty[2]),
        .soft_reset_0(sr[0]), .soft_reset_1(sr[1]), .soft_reset_2(sr[2]),
        .parity_done(pd), .low_pkt_valid(lpv),
        .fifo_sel(fifo_sel), .write_enb_reg(write_enb_reg), .detect_add(detect_add),
        .lfd_state(lfd_state), .ld_state(ld_state), .laf_state(laf_state),
        .full_state(full_state), .rst_int_reg(rst_int_reg), .busy(busy)
    );

    always #5 clock = ~clock;

    // Expected {detect,lfd,ld,laf,full,rst_int,busy,wr} for a named state.
    function automatic logic [7:0] exp_out(input int s);
        logic d, l1, l2, l3, f, ri, b, w;
        d  = (s == M_DA);
        l1 = (s == M_LFD);
        l2 = (s == M_LD);
        l3 = (s == M_LAF);
        f  = (s == M_FFS);
        ri = (s == M_CPE);
        b  = !((s == M_DA) || (s == M_LD));
        w  = (s == M_LD) || (s == M_LAF) || (s == M_LP);
        return {d, l1, l2, l3, f, ri, b, w};
    endfunction

    // Advance the reference model by one clock using the current inputs.
    task automatic model_step();
        int a, look, nxt;
        bit hit;
        a    = int'(din[1:0]);
        look = (ms == M_DA) ? a : maddr;
        hit  = (look != 3) && sr[look];
        nxt  = ms;
        if (hit) nxt = M_DA;
        else if (ms == M_DA) begin
            if (pv && a != 3) nxt = empty[a] ? M_LFD : M_WTE;
        end
        else if (ms == M_WTE) nxt = empty[maddr] ? M_LFD : M_WTE;
        else if (ms == M_LFD) nxt = M_LD;
        else if (ms == M_LD)  nxt = full[maddr] ? M_FFS : (!pv ? M_LP : M_LD);
        else if (ms == M_FFS) nxt = full[maddr] ? M_FFS : M_LAF;
        else if (ms == M_LAF) nxt = pd ? M_DA : (lpv ? M_LP : M_LD);
        else if (ms == M_LP)  nxt = M_CPE;
        else if (ms == M_CPE) nxt = full[maddr] ? M_FFS : M_DA;
        if (ms == M_DA && pv && a != 3) begin
            maddr = a;
            msel  = 3'b001 << a;
        end
        ms = nxt;
    endtask

    task automatic compare(input string tag, input int s, input logic [2:0] sel);
        logic [7:0] act;
        act = {detect_add, lfd_state, ld_state, laf_state, full_state, rst_int_reg, busy, write_enb_reg};
        tests++;
        if (act !== exp_out(s) || fifo_sel !== sel) begin
            fails++;
            $display("FAIL %s: got ctl=%b sel=%b, want ctl=%b sel=%b (state %0d)",
                     tag, act, fifo_sel, exp_out(s), sel, s);
        end
    endtask

    // One clock: model follows the edge; DUT is sampled on the falling edge.
    task automatic tick(input string tag);
        @(posedge clock);
        model_step();
        @(negedge clock);
        compare(tag, ms, msel);
    endtask

    task automatic idle_inputs();
        pv = 1'b0; din = 8'h00; full = 3'b000; empty = 3'b111;
        sr = 3'b000; pd = 1'b0; lpv = 1'b0;
    endtask

    typedef struct {
        logic       pv;
        logic [7:0] din;
        int         st;
    } vec_t;

    vec_t vtab[7];

    initial begin
        // Header 8'h0D: three payload bytes to FIFO 1.
        vtab[0] = '{1'b1, 8'h0D, M_LFD};
        vtab[1] = '{1'b1, 8'h11, M_LD};
        vtab[2] = '{1'b1, 8'h22, M_LD};
        vtab[3] = '{1'b1, 8'h33, M_LD};
        vtab[4] = '{1'b0, 8'h5A, M_LP};
        vtab[5] = '{1'b0, 8'h00, M_CPE};
        vtab[6] = '{1'b0, 8'h00, M_DA};

        idle_inputs();
        @(negedge clock);
        compare("reset_state", M_DA, 3'b000);
        reset = 1'b0;
        tick("idle_after_reset");

        // Table-driven packet to FIFO 1.
        for (int i = 0; i < 7; i++) begin
            pv  = vtab[i].pv;
            din = vtab[i].din;
            @(posedge clock);
            model_step();
            @(negedge clock);
            compare($sformatf("pkt1_row%0d", i), vtab[i].st, 3'b010);
        end

        // Destination FIFO 2 not empty: hold in WAIT_TILL_EMPTY for six clocks.
        pv = 1'b1; din = 8'h0E; empty = 3'b011;
        tick("wte_enter");
        din = 8'h41;
        for (int i = 0; i < 5; i++) tick("wte_hold");
        empty = 3'b111;
        tick("wte_to_lfd");
        tick("wte_ld");
        pv = 1'b0;
        tick("wte_lp");
        tick("wte_cpe");
        tick("wte_da");

        // FIFO 0 full for three clocks in mid-payload.
        pv = 1'b1; din = 8'h0C;
        tick("ff_lfd");
        din = 8'h77;
        tick("ff_ld");
        full = 3'b001;
        for (int i = 0; i < 3; i++) tick("ff_ffs");
        full = 3'b000;
        tick("ff_laf");
        tick("ff_back_ld");
        pv = 1'b0;
        tick("ff_lp");
        tick("ff_cpe");
        tick("ff_da");

        // Address 3 is ignored: stay in decode, selection unchanged.
        pv = 1'b1; din = 8'h07;
        tick("addr3_a");
        tick("addr3_b");
        compare("addr3_sel_kept", M_DA, 3'b001);

        // Soft reset of the active FIFO aborts the packet; soft reset 0 is ignored.
        din = 8'h05;
        tick("sr_lfd");
        din = 8'h99;
        tick("sr_ld");
        sr = 3'b011;
        tick("sr_abort");
        sr = 3'b000; pv = 1'b0;
        tick("sr_idle");

        // Async reset in the middle of LOAD_DATA.
        pv = 1'b1; din = 8'h05;
        tick("ar_lfd");
        din = 8'h12;
        tick("ar_ld");
        #2 reset = 1'b1;
        #1;
        ms = M_DA; maddr = 0; msel = 3'b000;
        compare("async_reset_same_cycle", M_DA, 3'b000);
        @(negedge clock);
        reset = 1'b0;
        idle_inputs();
        tick("post_reset");

        // Randomized traffic against the reference model.
        for (int c = 0; c < 3000; c++) begin
            pv    = ($urandom % 4) != 0;
            din   = 8'($urandom);
            full  = {($urandom % 5) == 0, ($urandom % 5) == 0, ($urandom % 5) == 0};
            empty = {($urandom % 3) != 0, ($urandom % 3) != 0, ($urandom % 3) != 0};
            sr    = {($urandom % 40) == 0, ($urandom % 40) == 0, ($urandom % 40) == 0};
            pd    = ($urandom % 6) == 0;
            lpv   = ($urandom % 6) == 0;
            tick("random");
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
